// File: rtl/mseq_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mseq_burst_ctrl_if
// Description : Host-side control/status bundle for the m-sequence burst
//               sequencer. The master modport is the host (drives start,
//               abort, seed and run configuration). The slave modport is the
//               sequencer (drives the pulse output and status flags).
//               Optional macro: MSEQ_SYNC_EN adds the sync_out status bit.
// Signals     : start, abort, seed_ld, seed[LFSR_W], period[DIV_W],
//               reps[8], gap[DIV_W]                   host -> sequencer
//               out_imp, chip_idx[LFSR_W], busy, done sequencer -> host
//               sync_out (MSEQ_SYNC_EN only)          sequencer -> host
// Revision    : 1.0  initial release
// ============================================================================
interface mseq_burst_ctrl_if #(
    parameter int DIV_W  = 19,
    parameter int LFSR_W = 6
);
    logic              start;
    logic              abort;
    logic              seed_ld;
    logic [LFSR_W-1:0] seed;
    logic [DIV_W-1:0]  period;
    logic [7:0]        reps;
    logic [DIV_W-1:0]  gap;
    logic              out_imp;
    logic [LFSR_W-1:0] chip_idx;
    logic              busy;
    logic              done;
`ifdef MSEQ_SYNC_EN
    logic              sync_out;
`endif

    modport master (
        output start, abort, seed_ld, seed, period, reps, gap,
        input  out_imp, chip_idx, busy, done
`ifdef MSEQ_SYNC_EN
        , input sync_out
`endif
    );

    modport slave (
        input  start, abort, seed_ld, seed, period, reps, gap,
        output out_imp, chip_idx, busy, done
`ifdef MSEQ_SYNC_EN
        , output sync_out
`endif
    );
endinterface
`default_nettype wire

// File: rtl/mseq_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mseq_burst_ctrl
// Description : Sequencer for the m-sequence pulse emitter path. Runs a
//               maximal-length LFSR (x^6+x^5+1, N = 63 chips) and emits a
//               one-clock pulse at the start of every '1' chip, one chip per
//               programmable period. A run is a programmable number of
//               identical repetitions separated by idle gaps.
//               Optional macro: MSEQ_SYNC_EN adds sync_out, a one-clock pulse
//               at chip 0 of every repetition, aligned with out_imp.
// Ports       : clk    - system clock
//               reset  - asynchronous reset, active-low
//               bus    - mseq_burst_ctrl_if.slave (start/abort/seed/config in,
//                        out_imp/chip_idx/busy/done[/sync_out] out)
// Revision    : 1.0  initial release
// ============================================================================
module mseq_burst_ctrl #(
    parameter int                DIV_W  = 19,
    parameter int                LFSR_W = 6,
    parameter logic [LFSR_W-1:0] SEED0  = 6'h3F
) (
    input wire logic          clk,
    input wire logic          reset,
    mseq_burst_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Index of the last chip, N-1 = 2^LFSR_W - 2
    localparam logic [LFSR_W-1:0] c_LAST_CHIP  = {{(LFSR_W-1){1'b1}}, 1'b0};
    localparam logic [DIV_W-1:0]  c_DIV_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]  c_PERIOD_MIN = {{(DIV_W-2){1'b0}}, 2'b10};

    state_t            r_state,    w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr,     w_lfsr_nxt;
    logic [LFSR_W-1:0] r_seed_reg, w_seed_reg_nxt;
    logic [DIV_W-1:0]  r_div_cnt,  w_div_cnt_nxt;
    logic [DIV_W-1:0]  r_div_last, w_div_last_nxt;
    logic [LFSR_W-1:0] r_chip_idx, w_chip_idx_nxt;
    logic [7:0]        r_rep_cnt,  w_rep_cnt_nxt;
    logic [7:0]        r_reps,     w_reps_nxt;
    logic [DIV_W-1:0]  r_gap,      w_gap_nxt;
    logic [DIV_W-1:0]  r_gap_cnt,  w_gap_cnt_nxt;
    logic              r_out_imp,  w_out_imp_nxt;
    logic              r_done,     w_done_nxt;

    logic [DIV_W-1:0]  w_period_eff;
    logic [LFSR_W-1:0] w_start_seed;
    logic [7:0]        w_rep_inc;
    logic              w_chip_end;
    logic              w_fb;

    // Period below 2 is clamped so that the pulse slot and the shift slot
    // never fall on the same clock.
    assign w_period_eff = (bus.period < c_PERIOD_MIN) ? c_PERIOD_MIN : bus.period;
    // A seed loaded in the same cycle as start is the one the run uses.
    assign w_start_seed = bus.seed_ld ? bus.seed : r_seed_reg;
    assign w_rep_inc    = r_rep_cnt + 8'd1;
    assign w_chip_end   = (r_div_cnt == r_div_last);
    // Fibonacci form shifting toward bit 0: new MSB = s[n] ^ s[n+5]
    assign w_fb         = r_lfsr[0] ^ r_lfsr[LFSR_W-1];

`ifdef MSEQ_SYNC_EN
    logic r_sync_out, w_sync_out_nxt;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_lfsr_nxt     = r_lfsr;
        w_seed_reg_nxt = r_seed_reg;
        w_div_cnt_nxt  = r_div_cnt;
        w_div_last_nxt = r_div_last;
        w_chip_idx_nxt = r_chip_idx;
        w_rep_cnt_nxt  = r_rep_cnt;
        w_reps_nxt     = r_reps;
        w_gap_nxt      = r_gap;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_out_imp_nxt  = 1'b0;
        w_done_nxt     = 1'b0;
`ifdef MSEQ_SYNC_EN
        w_sync_out_nxt = 1'b0;
`endif

        if ((r_state == S_IDLE) && bus.seed_ld) begin
            w_seed_reg_nxt = bus.seed;
        end

        if (bus.abort) begin
            w_state_nxt    = S_IDLE;
            w_div_cnt_nxt  = '0;
            w_chip_idx_nxt = '0;
            w_gap_cnt_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt    = S_RUN;
                        // An all-zero LFSR would lock up; substitute all-ones.
                        w_lfsr_nxt     = (w_start_seed == '0) ? '1 : w_start_seed;
                        w_div_cnt_nxt  = '0;
                        w_chip_idx_nxt = '0;
                        w_rep_cnt_nxt  = '0;
                        w_gap_cnt_nxt  = '0;
                        w_div_last_nxt = w_period_eff - c_DIV_ONE;
                        w_reps_nxt     = bus.reps;
                        w_gap_nxt      = bus.gap;
                    end
                end

                S_RUN: begin
                    if (r_div_cnt == '0) begin
                        w_out_imp_nxt = r_lfsr[0];
`ifdef MSEQ_SYNC_EN
                        w_sync_out_nxt = (r_chip_idx == '0);
`endif
                    end
                    if (w_chip_end) begin
                        w_div_cnt_nxt = '0;
                        // After N shifts the LFSR is back at its seed, so the
                        // next repetition needs no reload.
                        w_lfsr_nxt    = {w_fb, r_lfsr[LFSR_W-1:1]};
                        if (r_chip_idx == c_LAST_CHIP) begin
                            w_chip_idx_nxt = '0;
                            w_rep_cnt_nxt  = w_rep_inc;
                            // reps==0 means endless; the wrapped compare must
                            // not terminate it.
                            if ((r_reps != '0) && (w_rep_inc == r_reps)) begin
                                w_state_nxt = S_IDLE;
                                w_done_nxt  = 1'b1;
                            end else if (r_gap != '0) begin
                                w_state_nxt   = S_GAP;
                                w_gap_cnt_nxt = '0;
                            end
                        end else begin
                            w_chip_idx_nxt = r_chip_idx + 1'b1;
                        end
                    end else begin
                        w_div_cnt_nxt = r_div_cnt + c_DIV_ONE;
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == (r_gap - c_DIV_ONE)) begin
                        w_state_nxt   = S_RUN;
                        w_div_cnt_nxt = '0;
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + c_DIV_ONE;
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED0;
            r_seed_reg <= SEED0;
            r_div_cnt  <= '0;
            r_div_last <= '0;
            r_chip_idx <= '0;
            r_rep_cnt  <= '0;
            r_reps     <= '0;
            r_gap      <= '0;
            r_gap_cnt  <= '0;
            r_out_imp  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_seed_reg <= w_seed_reg_nxt;
            r_div_cnt  <= w_div_cnt_nxt;
            r_div_last <= w_div_last_nxt;
            r_chip_idx <= w_chip_idx_nxt;
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_reps     <= w_reps_nxt;
            r_gap      <= w_gap_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_out_imp  <= w_out_imp_nxt;
            r_done     <= w_done_nxt;
        end
    end

`ifdef MSEQ_SYNC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_out <= 1'b0;
        end else begin
            r_sync_out <= w_sync_out_nxt;
        end
    end

    assign bus.sync_out = r_sync_out;
`endif

    assign bus.out_imp  = r_out_imp;
    assign bus.chip_idx = r_chip_idx;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;

endmodule
`default_nettype wire
